// File: rtl/serial_bus_pkg.sv
// Shared state encoding and helpers for the bit-serial bus slave.
package serial_bus_pkg;

    typedef enum logic [3:0] {
        IDLE,
        REQ,
        SPLIT,
        READY,
        ADDR,
        MODE,
        WDATA,
        PAR,
        COMMIT,
        RDATA
    } slv_state_t;

    localparam logic MODE_WRITE = 1'b1;
    localparam logic MODE_READ  = 1'b0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/serial_slave_mem_regfile.sv
// Storage words for the serial slave: synchronous write, combinational read.
// Words are not reset; they power up at INIT_VAL.
module slave_regfile #(
    parameter int                 DEPTH    = 16,
    parameter int                 DATA_W   = 8,
    parameter int                 IDX_W    = 4,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  ridx_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: INIT_VAL};

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/serial_slave_mem.sv
// Bit-serial bus slave with local storage, SPLIT support and range check.
// Define SERIAL_SLAVE_PARITY_EN to add an even-parity bit to every frame.
module serial_slave_mem
    import serial_bus_pkg::*;
#(
    parameter int                ADDR_W     = 12,
    parameter int                DATA_W     = 8,
    parameter int                DEPTH      = 16,
    parameter int                ACK_CYCLES = 4,
    parameter logic [DATA_W-1:0] INIT_VAL   = DATA_W'(8'hD3)
) (
    input  logic clk,
    input  logic rstn,
    input  logic rx,
    output logic tx,
    input  logic busy,
    output logic split,
    output logic wr_done,
    output logic err
);

`ifdef SERIAL_SLAVE_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int IDX_W   = idx_w(DEPTH);
    localparam int RD_LAST = DATA_W + (PAR_EN ? 1 : 0);
    localparam int CNT_MAX = max3(ADDR_W, RD_LAST, ACK_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    slv_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tx_q, tx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              par_q, par_d;
    logic              rpar_q, rpar_d;

    logic              oor;
    logic              ok;
    logic              we;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_sel;

    // Compare one bit wider so DEPTH == 2**ADDR_W does not wrap to zero.
    assign oor    = {1'b0, addr_q} >= (ADDR_W+1)'(DEPTH);
    assign ok     = !oor && (!PAR_EN || (par_q == ^wdata_q));
    assign rd_sel = oor ? '0 : rd_word;

    slave_regfile #(
        .DEPTH    (DEPTH),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W),
        .INIT_VAL (INIT_VAL)
    ) u_regfile (
        .clk     (clk),
        .we_i    (we),
        .widx_i  (addr_q[IDX_W-1:0]),
        .wdata_i (wdata_q),
        .ridx_i  (addr_q[IDX_W-1:0]),
        .rdata_o (rd_word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        par_d   = par_q;
        rpar_d  = rpar_q;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (!rx) state_d = REQ;
            end
            REQ: begin
                if (busy) begin
                    state_d = SPLIT;
                end else begin
                    tx_d    = 1'b0;
                    state_d = READY;
                end
            end
            SPLIT: begin
                if (!busy && !rx) begin
                    tx_d    = 1'b0;
                    state_d = READY;
                end
            end
            READY: begin
                if (cnt_q == CNT_W'(ACK_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ADDR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ADDR: begin
                addr_d = {rx, addr_q[ADDR_W-1:1]};
                if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                    cnt_d   = '0;
                    state_d = MODE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MODE: begin
                unique case (rx)
                    MODE_WRITE: state_d = WDATA;
                    MODE_READ: begin
                        rdata_d = rd_sel;
                        rpar_d  = ^rd_sel;
                        state_d = RDATA;
                    end
                    default: state_d = IDLE;
                endcase
            end
            WDATA: begin
                wdata_d = {rx, wdata_q[DATA_W-1:1]};
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    cnt_d   = '0;
                    state_d = PAR_EN ? PAR : COMMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PAR: begin
                par_d   = rx;
                state_d = COMMIT;
            end
            COMMIT: begin
                we      = ok;
                tx_d    = 1'b1;
                state_d = IDLE;
            end
            RDATA: begin
                if (cnt_q < CNT_W'(DATA_W)) begin
                    tx_d    = rdata_q[0];
                    rdata_d = rdata_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                end else if (PAR_EN && cnt_q == CNT_W'(DATA_W)) begin
                    tx_d  = rpar_q;
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    tx_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            par_q   <= 1'b0;
            rpar_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            par_q   <= par_d;
            rpar_q  <= rpar_d;
        end
    end

    assign tx      = tx_q;
    assign split   = (state_q == SPLIT);
    assign wr_done = (state_q == COMMIT) && ok;
    assign err     = ((state_q == COMMIT) && !ok) ||
                     ((state_q == RDATA) && (cnt_q == CNT_W'(RD_LAST)) && oor);

endmodule

// File: tb/tb_serial_slave_mem.sv
// Directed bench for serial_slave_mem: frame table plus SPLIT, reset and parity cases.
module tb_serial_slave_mem;

    logic clk;
    logic rstn;
    logic rx;
    logic tx;
    logic busy;
    logic split;
    logic wr_done;
    logic err;

    int checks   = 0;
    int failures = 0;
    int wr_seen  = 0;
    int err_seen = 0;

    serial_slave_mem dut (
        .clk     (clk),
        .rstn    (rstn),
        .rx      (rx),
        .tx      (tx),
        .busy    (busy),
        .split   (split),
        .wr_done (wr_done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_done === 1'b1) wr_seen = wr_seen + 1;
        if (err === 1'b1) err_seen = err_seen + 1;
    end

    typedef struct {
        bit          wr;
        logic [11:0] a;
        logic [7:0]  d;
        logic        p;
        logic [7:0]  exp_rd;
        int          exp_wr;
        int          exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks = checks + 1;
        if (act !== exp_v) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp_v);
        end
    endtask

    task automatic frame(
        input  bit          wr,
        input  logic [11:0] a,
        input  logic [7:0]  d,
        input  logic        p,
        input  int          hold,
        input  int          abort_bit,
        output logic [7:0]  rd,
        output logic        rp
    );
        int  n;
        bit  got;
        int  split_bad;
        int  eng_bad;
        rd = '0;
        rp = 1'b0;
        split_bad = 0;
        eng_bad = 0;
        got = 1'b0;
        n = 0;
        rx = 1'b0;
        busy = (hold > 0);
        while (n < 200) begin
            @(negedge clk);
            n = n + 1;
            if (tx === 1'b0) begin
                got = 1'b1;
                break;
            end
            if (hold > 0 && n >= 2) begin
                if (split !== 1'b1 || tx !== 1'b1) split_bad = split_bad + 1;
                if (n >= hold) busy = 1'b0;
            end
        end
        if (!got) begin
            chk("handshake_timeout", 32'(n), 32'd0);
            rx = 1'b1;
            busy = 1'b0;
            return;
        end
        if (hold > 0) begin
            chk("split_hold", 32'(split_bad), 32'd0);
            chk("split_release", {31'd0, split}, 32'd0);
        end else begin
            chk("req_latency", 32'(n), 32'd2);
        end
        rx = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (tx !== 1'b0) eng_bad = eng_bad + 1;
        end
        for (int i = 0; i < 12; i++) begin
            rx = a[i];
            @(negedge clk);
            if (tx !== 1'b0) eng_bad = eng_bad + 1;
        end
        rx = wr;
        @(negedge clk);
        if (wr) begin
            for (int i = 0; i < 8; i++) begin
                if (i == abort_bit) begin
                    rstn = 1'b0;
                    #1;
                    chk("abort_tx", {31'd0, tx}, 32'd1);
                    chk("abort_split", {31'd0, split}, 32'd0);
                    @(negedge clk);
                    rstn = 1'b1;
                    rx = 1'b1;
                    @(negedge clk);
                    return;
                end
                rx = d[i];
                @(negedge clk);
                if (tx !== 1'b0) eng_bad = eng_bad + 1;
            end
`ifdef SERIAL_SLAVE_PARITY_EN
            rx = p;
            @(negedge clk);
            if (tx !== 1'b0) eng_bad = eng_bad + 1;
`endif
            rx = 1'b1;
            @(negedge clk);
        end else begin
            rx = 1'b1;
            if (tx !== 1'b0) eng_bad = eng_bad + 1;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                rd[i] = tx;
            end
`ifdef SERIAL_SLAVE_PARITY_EN
            @(negedge clk);
            rp = tx;
`endif
            @(negedge clk);
        end
        chk("engaged_tx_low", 32'(eng_bad), 32'd0);
        chk("end_tx_idle", {31'd0, tx}, 32'd1);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int hold, input string tag);
        int          w0;
        int          e0;
        logic [7:0]  rd;
        logic        rp;
        w0 = wr_seen;
        e0 = err_seen;
        frame(v.wr, v.a, v.d, v.p, hold, -1, rd, rp);
        if (!v.wr) begin
            chk({tag, "_rdata"}, {24'd0, rd}, {24'd0, v.exp_rd});
`ifdef SERIAL_SLAVE_PARITY_EN
            chk({tag, "_rpar"}, {31'd0, rp}, {31'd0, v.p});
`endif
        end
        chk({tag, "_wr_done"}, 32'(wr_seen - w0), 32'(v.exp_wr));
        chk({tag, "_err"}, 32'(err_seen - e0), 32'(v.exp_err));
    endtask

    vec_t vt [12];

    initial begin
        int         w0;
        logic [7:0] rd;
        logic       rp;
        vec_t       hv;

        vt[0]  = '{1'b0, 12'h00F, 8'h00, 1'b1, 8'hD3, 0, 0};
        vt[1]  = '{1'b1, 12'h005, 8'hA5, 1'b0, 8'h00, 1, 0};
        vt[2]  = '{1'b0, 12'h005, 8'h00, 1'b0, 8'hA5, 0, 0};
        vt[3]  = '{1'b1, 12'h010, 8'h3C, 1'b0, 8'h00, 0, 1};
        vt[4]  = '{1'b0, 12'h000, 8'h00, 1'b1, 8'hD3, 0, 0};
        vt[5]  = '{1'b0, 12'h010, 8'h00, 1'b0, 8'h00, 0, 1};
        vt[6]  = '{1'b1, 12'h00F, 8'h5A, 1'b0, 8'h00, 1, 0};
        vt[7]  = '{1'b0, 12'h00F, 8'h00, 1'b0, 8'h5A, 0, 0};
        vt[8]  = '{1'b1, 12'hFFF, 8'h11, 1'b0, 8'h00, 0, 1};
        vt[9]  = '{1'b0, 12'h00F, 8'h00, 1'b0, 8'h5A, 0, 0};
        vt[10] = '{1'b1, 12'h000, 8'hFF, 1'b0, 8'h00, 1, 0};
        vt[11] = '{1'b0, 12'h000, 8'h00, 1'b0, 8'hFF, 0, 0};

        rstn = 1'b0;
        rx   = 1'b1;
        busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_split", {31'd0, split}, 32'd0);
        chk("rst_wr_done", {31'd0, wr_done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_vec(vt[i], 0, $sformatf("vec%0d", i));
        end

        hv = '{1'b0, 12'h005, 8'h00, 1'b0, 8'hA5, 0, 0};
        run_vec(hv, 20, "split_read");

        w0 = wr_seen;
        frame(1'b1, 12'h003, 8'h99, 1'b0, 0, 4, rd, rp);
        chk("abort_no_write", 32'(wr_seen - w0), 32'd0);
        hv = '{1'b0, 12'h003, 8'h00, 1'b1, 8'hD3, 0, 0};
        run_vec(hv, 0, "after_abort");

`ifdef SERIAL_SLAVE_PARITY_EN
        hv = '{1'b1, 12'h007, 8'h07, 1'b1, 8'h00, 1, 0};
        run_vec(hv, 0, "par_good_wr");
        hv = '{1'b0, 12'h007, 8'h00, 1'b1, 8'h07, 0, 0};
        run_vec(hv, 0, "par_good_rd");
        hv = '{1'b1, 12'h006, 8'h07, 1'b0, 8'h00, 0, 1};
        run_vec(hv, 0, "par_bad_wr");
        hv = '{1'b0, 12'h006, 8'h00, 1'b1, 8'hD3, 0, 0};
        run_vec(hv, 0, "par_bad_rd");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
